fnd_scan_controller: RTL and testbench

Time-multiplexed digit scanner for the 4-digit FND. It drives the digit-select and enable inputs of the BCD-to-FND decoder in the calculator top level. It steps through digits 0..3 at a fixed slot rate and skips masked-off digits. It can blank each slot briefly after a digit change to suppress ghosting.

---
 rtl/fnd_pkg.sv | 42 ++++
 rtl/fnd_prescaler.sv | 46 ++++
 rtl/fnd_scan_controller.sv | 124 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// ----------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the 4-digit FND scan logic.
//   FND_DIGITS      number of digits on the display
//   FND_SEL_W       width of a digit index
//   scan_state_e    per-slot visibility state (SCAN_BLANK, SCAN_SHOW)
//   fnd_next_digit  next enabled digit after sel, searched cyclically;
//                   returns sel unchanged when no digit is enabled
// ----------------------------------------------------------------------------
package fnd_pkg;

    localparam int FND_DIGITS = 4;
    localparam int FND_SEL_W  = 2;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_e;

    // Candidates are sel+1, sel+2, sel+3 and finally sel itself (offset 4
    // wraps to 0 in FND_SEL_W bits), so a lone enabled current digit is
    // re-selected and an all-zero mask leaves sel untouched.
    function automatic logic [FND_SEL_W-1:0] fnd_next_digit(
        input logic [FND_SEL_W-1:0]  sel,
        input logic [FND_DIGITS-1:0] mask
    );
        logic [FND_SEL_W-1:0] nxt;
        logic [FND_SEL_W-1:0] cand;
        logic                 found;
        nxt   = sel;
        found = 1'b0;
        for (int i = 1; i <= FND_DIGITS; i++) begin
            cand = sel + FND_SEL_W'(i);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fnd_prescaler.sv
// ----------------------------------------------------------------------------
// fnd_prescaler
// Slot timer: counts 0..DIV-1 and flags the last cycle of each slot.
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_hold     freezes the count while high
//   o_count    current position inside the slot
//   o_wrap     high in the cycle the count wraps (count = DIV-1, no hold)
// ----------------------------------------------------------------------------
module fnd_prescaler #(
    parameter  int unsigned DIV = 25000,
    localparam int unsigned CW  = $clog2(DIV)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_hold,
    output logic [CW-1:0] o_count,
    output logic          o_wrap
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign o_wrap  = (count_q == LAST) && !i_hold;
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (o_wrap) begin
            count_d = '0;
        end else if (!i_hold) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// fnd_scan_controller
// Time-multiplexed scanner for a 4-digit FND. Steps through the enabled
// digits, one DIV-cycle slot each, and optionally blanks the first BLANK
// cycles of every slot to suppress ghosting.
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_digitMask    bit n = 1 enables digit n
//   i_hold         freezes slot timing, digit and blank/show state
//   o_digitSelect  digit currently scanned (registered)
//   o_en           decoder enable: slot visible and digit enabled (registered)
//   o_tick         one-cycle pulse in the first cycle of each slot (registered)
// Build option: define FND_SCAN_BLANK_EN to compile the blanking window.
// Without it the slot is visible for its full length and BLANK is ignored.
// ----------------------------------------------------------------------------
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned DIV   = 25000,
    parameter int unsigned BLANK = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [FND_DIGITS-1:0] i_digitMask,
    input  logic                  i_hold,
    output logic [FND_SEL_W-1:0]  o_digitSelect,
    output logic                  o_en,
    output logic                  o_tick
);

    localparam int unsigned CW = $clog2(DIV);

`ifdef FND_SCAN_BLANK_EN
    localparam scan_state_e   STATE_RST  = SCAN_BLANK;
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
`else
    localparam scan_state_e   STATE_RST  = SCAN_SHOW;
`endif

    logic [CW-1:0]        slot_count;
    logic                 slot_wrap;

    scan_state_e          state_q;
    scan_state_e          state_d;
    logic [FND_SEL_W-1:0] sel_q;
    logic [FND_SEL_W-1:0] sel_d;
    logic                 en_q;
    logic                 en_d;
    logic                 tick_q;
    logic                 tick_d;

    fnd_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_hold    (i_hold),
        .o_count   (slot_count),
        .o_wrap    (slot_wrap)
    );

`ifndef FND_SCAN_BLANK_EN
    // Slot position and BLANK only matter for the blanking window.
    logic unused_cfg;
    assign unused_cfg = ^{slot_count, BLANK[0]};
`endif

    // Next-state and output logic. slot_wrap already includes !i_hold, so
    // a held cycle leaves sel and the state untouched and never ticks.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tick_d  = slot_wrap;

        if (slot_wrap) begin
            sel_d = fnd_next_digit(sel_q, i_digitMask);
        end

`ifdef FND_SCAN_BLANK_EN
        unique case (state_q)
            SCAN_BLANK: begin
                // With BLANK = 0 the window is empty: leave at once (only
                // reachable straight out of reset).
                if (slot_wrap) begin
                    state_d = (BLANK == 0) ? SCAN_SHOW : SCAN_BLANK;
                end else if (!i_hold && (BLANK == 0 || slot_count == BLANK_LAST)) begin
                    state_d = SCAN_SHOW;
                end
            end
            SCAN_SHOW: begin
                if (slot_wrap) begin
                    state_d = (BLANK == 0) ? SCAN_SHOW : SCAN_BLANK;
                end
            end
            default: state_d = SCAN_BLANK;
        endcase
`else
        state_d = SCAN_SHOW;
`endif

        // Look ahead to the next-cycle state and digit so the registered
        // enable lines up with the registered digit select.
        en_d = (state_d == SCAN_SHOW) && i_digitMask[sel_d];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= STATE_RST;
            sel_q   <= '0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
        end
    end

    assign o_digitSelect = sel_q;
    assign o_en          = en_q;
    assign o_tick        = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_fnd_scan_controller
// Bench for fnd_scan_controller with DIV = 8, BLANK = 2. The reference model
// tracks slot position and digit directly; expected outputs are queued per
// cycle and compared by an independent monitor. Works with or without
// FND_SCAN_BLANK_EN.
// ----------------------------------------------------------------------------
module tb_fnd_scan_controller;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
`ifdef FND_SCAN_BLANK_EN
    localparam int VIS_FROM = BLANK;
`else
    localparam int VIS_FROM = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mask;
    logic       hold;
    logic [1:0] dut_sel;
    logic       dut_en;
    logic       dut_tick;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_digitMask   (mask),
        .i_hold        (hold),
        .o_digitSelect (dut_sel),
        .o_en          (dut_en),
        .o_tick        (dut_tick)
    );

    // ---------------- scoreboard state ----------------
    logic [3:0] exp_q[$];       // {sel[1:0], en, tick}
    int         tick_times[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    // Reference model: position in slot and current digit.
    int m_pos = 0;
    int m_dig = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int next_dig(input int dig, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            if (m[(dig + k) % 4]) return (dig + k) % 4;
        end
        return dig;
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of inputs at the falling edge and queues the outputs
    // expected after the following rising edge.
    task automatic step(input logic [3:0] m, input logic h, input logic r);
        logic tk;
        logic e;
        @(negedge clk);
        mask  = m;
        hold  = h;
        rst_n = r;
        if (!r) begin
            m_pos = 0;
            m_dig = 0;
            exp_q.push_back(4'b0000);
        end else begin
            tk = 1'b0;
            if (!h) begin
                if (m_pos == DIV - 1) begin
                    m_pos = 0;
                    m_dig = next_dig(m_dig, m);
                    tk    = 1'b1;
                end else begin
                    m_pos++;
                end
            end
            e = (m_pos >= VIS_FROM) && m[m_dig];
            exp_q.push_back({2'(m_dig), e, tk});
        end
    endtask

    task automatic run_until(input int dig, input int pos, input logic [3:0] m, input string name);
        int n;
        n = 0;
        while (!(m_dig == dig && m_pos == pos) && n < 64) begin
            step(m, 1'b0, 1'b1);
            n++;
        end
        checks++;
        if (!(m_dig == dig && m_pos == pos)) begin
            errors++;
            $display("FAIL %s: target digit %0d pos %0d not reached within 64 cycles", name, dig, pos);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut_tick === 1'b1) tick_times.push_back(cyc);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("digit_select", 8'(dut_sel),  8'(exp[3:2]));
                check("en",           8'(dut_en),   8'(exp[1]));
                check("tick",         8'(dut_tick), 8'(exp[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rel_cyc;
        int first_tick;
        logic [3:0] rmask;
        logic       rhold;
        logic       rrst;

        rst_n = 1'b0;
        mask  = 4'h0;
        hold  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_sel",  8'(dut_sel),  8'd0);
        check("reset_en",   8'(dut_en),   8'd0);
        check("reset_tick", 8'(dut_tick), 8'd0);

        // All digits: 0,1,2,3,0 with blanking at the start of each slot.
        step(4'hF, 1'b0, 1'b0);
        repeat (40) step(4'hF, 1'b0, 1'b1);

        // Digits 0 and 2, then switch to digit 3 only in the middle of slot 2.
        repeat (24) step(4'h5, 1'b0, 1'b1);
        run_until(2, 4, 4'h5, "reach_dig2_mid");
        repeat (20) step(4'h8, 1'b0, 1'b1);

        // No digits: prescaler keeps ticking, enable stays low.
        repeat (40) step(4'h0, 1'b0, 1'b1);

        // Hold for 5 cycles while digit 1 is showing: slot stretches to 13.
        run_until(1, 0, 4'hF, "reach_dig1_start");
        run_until(1, 4, 4'hF, "reach_dig1_show");
        repeat (5) step(4'hF, 1'b1, 1'b1);
        run_until(2, 0, 4'hF, "reach_dig2_start");
        step(4'hF, 1'b0, 1'b1);
        if (tick_times.size() >= 2)
            check("hold_slot_len", 8'(tick_times[$] - tick_times[$-1]), 8'd13);
        else
            check("hold_slot_ticks", 8'(tick_times.size()), 8'd2);

        // Reset in the middle of digit 2's slot.
        run_until(2, 5, 4'hF, "reach_dig2_pos5");
        step(4'hF, 1'b0, 1'b0);
        #1;
        check("midreset_sel",  8'(dut_sel),  8'd0);
        check("midreset_en",   8'(dut_en),   8'd0);
        check("midreset_tick", 8'(dut_tick), 8'd0);
        step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b1);
        rel_cyc = cyc;
        repeat (12) step(4'hF, 1'b0, 1'b1);
        first_tick = -1;
        foreach (tick_times[i]) begin
            if (first_tick < 0 && tick_times[i] > rel_cyc) first_tick = tick_times[i];
        end
        check("first_tick_after_reset", 8'(first_tick - rel_cyc), 8'd8);

        // Randomized masks, holds and occasional resets.
        rmask = 4'hF;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rmask = 4'($urandom_range(0, 15));
            rhold = ($urandom_range(0, 5) == 0);
            rrst  = ($urandom_range(0, 99) != 0);
            step(rmask, rhold, rrst);
        end
        step(rmask, 1'b0, 1'b1);

        @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
